// File: rtl/acu_issue_pkg.sv
// Shared RV32I execution types for the arithmetic/compare issue unit.
//   rs_t      : reservation-station entry (ROB tag, opcode, two operands)
//   sal_t     : result presented to the CDB (ROB tag plus 32-bit value)
//   alu_ops   : ALU opcode encoding carried in rs_t.op
//   cmp_ops   : compare opcode encoding carried in rs_t.op
//   ACU_SEL_* : per-entry execute select (ALU or compare)
package rv32i_types;

   localparam int TAG_W = 5;

   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops;

   typedef enum logic [2:0] {
      cmp_beq  = 3'b000,
      cmp_bne  = 3'b001,
      cmp_blt  = 3'b100,
      cmp_bge  = 3'b101,
      cmp_bltu = 3'b110,
      cmp_bgeu = 3'b111
   } cmp_ops;

   localparam logic ACU_SEL_ALU = 1'b0;
   localparam logic ACU_SEL_CMP = 1'b1;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [2:0]       op;
      logic [31:0]      rs1_v;
      logic [31:0]      rs2_v;
   } rs_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      value;
   } sal_t;

endpackage

// File: rtl/acu_issue_lane.sv
// Single-entry combinational execute for one issue lane.
//   entry     : selected reservation-station entry
//   operation : ACU_SEL_ALU or ACU_SEL_CMP
//   result    : tag copied from the entry plus the computed value
module acu_lane
   import rv32i_types::*;
(
   input  rs_t  entry,
   input  logic operation,
   output sal_t result
);

   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_val;
   logic        cmp_bit;

   assign a = entry.rs1_v;
   assign b = entry.rs2_v;

   always_comb begin
      alu_val = '0;
      case (alu_ops'(entry.op))
         alu_add: alu_val = a + b;
         alu_sll: alu_val = a << b[4:0];
         alu_sra: alu_val = unsigned'($signed(a) >>> b[4:0]);
         alu_sub: alu_val = a - b;
         alu_xor: alu_val = a ^ b;
         alu_srl: alu_val = a >> b[4:0];
         alu_or:  alu_val = a | b;
         alu_and: alu_val = a & b;
         default: alu_val = '0;
      endcase
   end

   // Unused compare encodings (3'b010, 3'b011) evaluate false.
   always_comb begin
      cmp_bit = 1'b0;
      case (entry.op)
         cmp_beq:  cmp_bit = (a == b);
         cmp_bne:  cmp_bit = (a != b);
         cmp_blt:  cmp_bit = ($signed(a) <  $signed(b));
         cmp_bge:  cmp_bit = ($signed(a) >= $signed(b));
         cmp_bltu: cmp_bit = (a <  b);
         cmp_bgeu: cmp_bit = (a >= b);
         default:  cmp_bit = 1'b0;
      endcase
   end

   always_comb begin
      result.tag   = entry.tag;
      result.value = (operation == ACU_SEL_CMP) ? {31'd0, cmp_bit} : alu_val;
   end

endmodule

// File: rtl/acu_issue.sv
// Multi-lane ALU/compare issue unit between the arithmetic RS and the CDB.
// Scans `size` RS entries from a round-robin pointer, picks up to `lanes`
// ready entries, executes them in acu_lane instances and registers the
// results with per-lane valid bits. Output registers hold under CDB
// backpressure; flush drops the valids.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop registered results, suppress issue
//   data            : RS entries
//   ready           : per-entry ready mask
//   acu_operation   : per-entry select (0 ALU, 1 compare)
//   cdb_stall       : CDB cannot accept this cycle
//   issued          : combinational mask of entries consumed this cycle
//   out, out_valid  : registered lane results and valids
module acu_issue
   import rv32i_types::*;
#(
   parameter int size  = 15,
   parameter int lanes = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  rs_t               data          [size],
   input  logic [size-1:0]   ready,
   input  logic              acu_operation [size],
   input  logic              cdb_stall,
   output logic [size-1:0]   issued,
   output sal_t              out           [lanes],
   output logic [lanes-1:0]  out_valid
);

   localparam int PTR_W = (size > 1) ? $clog2(size) : 1;
   localparam int CNT_W = $clog2(size + 1);

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   sal_t             out_q [lanes];
   sal_t             out_d [lanes];
   logic [lanes-1:0] out_valid_q, out_valid_d;

   logic             stall_hold;
   logic             issue_en;

   // A stall only matters when there is something to hold; an empty
   // output stage keeps filling.
   assign stall_hold = cdb_stall && (|out_valid_q);
   assign issue_en   = !flush && !stall_hold;

   // Scan order: offset j maps to entry (rr_ptr + j) mod size.
   // hit_cnt[j] counts ready entries at offsets below j, so the entry at
   // offset j goes to lane hit_cnt[j].
   logic [PTR_W-1:0] scan_idx [size];
   logic [size-1:0]  scan_hit;
   logic [CNT_W-1:0] hit_cnt  [size+1];

   assign hit_cnt[0] = '0;

   for (genvar j = 0; j < size; j++) begin : g_scan
      logic [PTR_W:0] sum;
      assign sum         = {1'b0, rr_ptr_q} + (PTR_W+1)'(j);
      assign scan_idx[j] = (sum >= (PTR_W+1)'(size)) ?
                           PTR_W'(sum - (PTR_W+1)'(size)) : sum[PTR_W-1:0];
      assign scan_hit[j]  = ready[scan_idx[j]];
      assign hit_cnt[j+1] = hit_cnt[j] + CNT_W'(scan_hit[j]);
   end

   logic [PTR_W-1:0] sel_idx  [lanes];
   logic [lanes-1:0] lane_hit;
   sal_t             lane_res [lanes];

   for (genvar k = 0; k < lanes; k++) begin : g_lane
      logic             hit_l;
      logic [PTR_W-1:0] idx_l;

      always_comb begin
         hit_l = 1'b0;
         idx_l = '0;
         for (int j = 0; j < size; j++) begin
            if (scan_hit[j] && (hit_cnt[j] == CNT_W'(k))) begin
               hit_l = 1'b1;
               idx_l = scan_idx[j];
            end
         end
      end

      assign lane_hit[k] = hit_l;
      assign sel_idx[k]  = idx_l;

      acu_lane u_lane (
         .entry     (data[idx_l]),
         .operation (acu_operation[idx_l]),
         .result    (lane_res[k])
      );
   end

   // Highest-numbered busy lane holds the last entry in scan order.
   logic [PTR_W-1:0] last_idx;
   logic [PTR_W-1:0] next_ptr;

   always_comb begin
      last_idx = rr_ptr_q;
      for (int k = 0; k < lanes; k++) begin
         if (lane_hit[k]) last_idx = sel_idx[k];
      end
      next_ptr = (last_idx == PTR_W'(size - 1)) ? '0 : last_idx + 1'b1;
   end

   always_comb begin
      issued = '0;
      if (!rst && issue_en) begin
         for (int k = 0; k < lanes; k++) begin
            if (lane_hit[k]) issued[sel_idx[k]] = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      if (flush) begin
         out_valid_d = '0;
      end else if (!stall_hold) begin
         for (int k = 0; k < lanes; k++) begin
            out_valid_d[k] = lane_hit[k];
            out_d[k]       = lane_hit[k] ? lane_res[k] : '0;
         end
         if (|lane_hit) rr_ptr_d = next_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         out_valid_q <= '0;
         for (int k = 0; k < lanes; k++) out_q[k] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         for (int k = 0; k < lanes; k++) out_q[k] <= out_d[k];
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_acu_issue.sv
// Randomized + directed bench for acu_issue against a queue-based model.
module tb_acu_issue;
   import rv32i_types::*;

   localparam int SIZE  = 15;
   localparam int LANES = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             cdb_stall;
   rs_t              data [SIZE];
   logic [SIZE-1:0]  ready;
   logic             acu_operation [SIZE];
   logic [SIZE-1:0]  issued;
   sal_t             out [LANES];
   logic [LANES-1:0] out_valid;

   acu_issue #(.size(SIZE), .lanes(LANES)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .data          (data),
      .ready         (ready),
      .acu_operation (acu_operation),
      .cdb_stall     (cdb_stall),
      .issued        (issued),
      .out           (out),
      .out_valid     (out_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state
   int          m_rr;
   bit          m_valid [LANES];
   logic [TAG_W-1:0] m_tag [LANES];
   logic [31:0] m_val [LANES];

   function automatic logic [31:0] ref_result(input rs_t e, input logic is_cmp);
      longint sa, sb;
      longint unsigned ua, ub;
      int sh;
      ua = e.rs1_v; ub = e.rs2_v;
      sa = $signed(e.rs1_v); sb = $signed(e.rs2_v);
      sh = int'(e.rs2_v % 32);
      if (!is_cmp) begin
         case (int'(e.op))
            0: return 32'(ua + ub);
            1: return 32'(ua * (64'd1 << sh));
            2: return 32'(sa >>> sh);
            3: return 32'(ua - ub);
            4: return e.rs1_v ^ e.rs2_v;
            5: return 32'(ua / (64'd1 << sh));
            6: return e.rs1_v | e.rs2_v;
            default: return e.rs1_v & e.rs2_v;
         endcase
      end
      case (int'(e.op))
         0: return (ua == ub) ? 32'd1 : 32'd0;
         1: return (ua != ub) ? 32'd1 : 32'd0;
         4: return (sa <  sb) ? 32'd1 : 32'd0;
         5: return (sa >= sb) ? 32'd1 : 32'd0;
         6: return (ua <  ub) ? 32'd1 : 32'd0;
         7: return (ua >= ub) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Inputs are already driven; check issued, advance model, clock, check outputs.
   task automatic step();
      int picks[$];
      bit any_v;
      bit en;
      bit was_rst;
      logic [SIZE-1:0] exp_issued;
      any_v = 0;
      for (int k = 0; k < LANES; k++) any_v |= m_valid[k];
      en = !rst && !flush && !(cdb_stall && any_v);
      exp_issued = '0;
      if (en) begin
         for (int j = 0; j < SIZE; j++) begin
            int idx;
            idx = (m_rr + j) % SIZE;
            if (ready[idx] && picks.size() < LANES) begin
               picks.push_back(idx);
               exp_issued[idx] = 1'b1;
            end
         end
      end
      #1;
      check("issued", 64'(issued), 64'(exp_issued));
      was_rst = rst;
      if (rst) begin
         m_rr = 0;
         for (int k = 0; k < LANES; k++) begin
            m_valid[k] = 0; m_tag[k] = '0; m_val[k] = '0;
         end
      end else if (flush) begin
         for (int k = 0; k < LANES; k++) m_valid[k] = 0;
      end else if (en) begin
         for (int k = 0; k < LANES; k++) begin
            if (k < picks.size()) begin
               m_valid[k] = 1;
               m_tag[k]   = data[picks[k]].tag;
               m_val[k]   = ref_result(data[picks[k]], acu_operation[picks[k]]);
            end else begin
               m_valid[k] = 0;
            end
         end
         if (picks.size() > 0) m_rr = (picks[picks.size()-1] + 1) % SIZE;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < LANES; k++) begin
         check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_valid[k]));
         if (m_valid[k] || was_rst) begin
            check($sformatf("out_tag[%0d]", k), 64'(out[k].tag), 64'(m_tag[k]));
            check($sformatf("out_val[%0d]", k), 64'(out[k].value), 64'(m_val[k]));
         end
      end
      check("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_rr));
   endtask

   task automatic set_entry(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic cmp, input logic [TAG_W-1:0] tag);
      data[i].rs1_v = a; data[i].rs2_v = b; data[i].op = op; data[i].tag = tag;
      acu_operation[i] = cmp;
   endtask

   task automatic rand_entry(input int i);
      logic [31:0] a;
      a = $urandom;
      set_entry(i, a, ($urandom_range(0, 3) == 0) ? a : $urandom,
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                TAG_W'($urandom_range(0, 31)));
   endtask

   initial begin
      logic [31:0] held;
      rst = 1'b1; flush = 1'b0; cdb_stall = 1'b0; ready = '0;
      m_rr = 0;
      for (int k = 0; k < LANES; k++) begin
         m_valid[k] = 0; m_tag[k] = '0; m_val[k] = '0;
      end
      for (int i = 0; i < SIZE; i++) set_entry(i, 32'(i), 32'd1, 3'd0, 1'b0, TAG_W'(i));

      // Reset
      step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;

      // Single op: 5 + 7, tag 3
      set_entry(0, 32'd5, 32'd7, 3'd0, 1'b0, 5'd3);
      ready = 15'h0001;
      step();
      check("single_valid", 64'(out_valid), 64'd1);
      check("single_val", 64'(out[0].value), 64'd12);
      check("single_tag", 64'(out[0].tag), 64'd3);

      // Dual issue from rr_ptr 0
      set_entry(0, 32'd0, 32'd1, 3'd0, 1'b0, 5'd0);
      rst = 1'b1; ready = '0; step(); rst = 1'b0;
      ready = 15'h7FFF; step();
      check("dual_tag0", 64'(out[0].tag), 64'd0);
      check("dual_tag1", 64'(out[1].tag), 64'd1);
      check("dual_rr", 64'(dut.rr_ptr_q), 64'd2);
      ready = 15'h7FFC; step();
      check("rr2_tag0", 64'(out[0].tag), 64'd2);
      check("rr2_tag1", 64'(out[1].tag), 64'd3);

      // Wrap from rr_ptr 14
      ready = 15'h2000; step();
      check("pre_wrap_rr", 64'(dut.rr_ptr_q), 64'd14);
      ready = 15'h4001; step();
      check("wrap_tag0", 64'(out[0].tag), 64'd14);
      check("wrap_tag1", 64'(out[1].tag), 64'd0);
      check("wrap_rr", 64'(dut.rr_ptr_q), 64'd1);

      // Compare blt
      rst = 1'b1; ready = '0; step(); rst = 1'b0;
      set_entry(5, 32'hFFFF_FFFD, 32'd2, 3'b100, 1'b1, 5'd9);
      ready = 15'h0020; step();
      check("blt_true", 64'(out[0].value), 64'd1);
      set_entry(5, 32'd2, 32'hFFFF_FFFD, 3'b100, 1'b1, 5'd9);
      step();
      check("blt_false", 64'(out[0].value), 64'd0);

      // Backpressure for 3 cycles, then release
      held = out[0].value;
      cdb_stall = 1'b1; ready = 15'h0080;
      for (int c = 0; c < 3; c++) begin
         step();
         check("stall_hold", 64'(out[0].value), 64'(held));
         check("stall_issued", 64'(issued), 64'd0);
      end
      cdb_stall = 1'b0; #1;
      check("release_issued", 64'(issued), 64'h0080);
      step();
      check("release_tag", 64'(out[0].tag), 64'(data[7].tag));

      // Flush during stall
      cdb_stall = 1'b1; flush = 1'b1; step();
      check("flush_valid", 64'(out_valid), 64'd0);
      flush = 1'b0; cdb_stall = 1'b0;

      // Reset with valid outputs
      ready = 15'h7FFF; step();
      rst = 1'b1; step();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_out0", 64'(out[0]), 64'd0);
      check("rst_rr", 64'(dut.rr_ptr_q), 64'd0);
      rst = 1'b0;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < SIZE; i++) if ($urandom_range(0, 9) < 3) rand_entry(i);
         ready     = SIZE'($urandom);
         if ($urandom_range(0, 3) == 0) ready = ready & SIZE'($urandom);
         rst       = ($urandom_range(0, 99) < 2);
         flush     = ($urandom_range(0, 99) < 10);
         cdb_stall = ($urandom_range(0, 99) < 30);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/acu_issue.md
# acu_issue

Pipelined, multi-lane successor to the combinational arithmetic/compare unit. Each cycle it scans `size` reservation-station entries, selects up to `lanes` ready entries in round-robin order, and executes each one as either an ALU or a compare operation. Results are registered and presented to the common data bus with per-lane valid bits and bus backpressure. It sits between the arithmetic reservation station and the CDB arbiter.

## Interface
- `size`, default 15: number of reservation-station entries scanned.
- `lanes`, default 2: number of execution lanes, i.e. results per cycle; 1 ≤ `lanes` ≤ `size`.
- `clk` in, 1: sole clock; all state updates on its rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `flush` in, 1: pipeline flush on branch mispredict.
- `data` in, `rs_t [size]`: reservation-station entries (operands, opcode, ROB tag).
- `ready` in, `[size-1:0]`: entry i has both operands valid and is not yet issued.
- `acu_operation` in, `logic [size]`: 0 selects ALU, 1 selects compare.
- `cdb_stall` in, 1: CDB cannot accept results this cycle.
- `issued` out, `[size-1:0]`: combinational one-hot-per-entry mask of entries consumed this cycle; the RS frees them at the next edge.
- `out` out, `sal_t [lanes]`: registered results (tag plus value).
- `out_valid` out, `[lanes-1:0]`: registered lane valid bits.

## Operation
- Issue is enabled when `!flush && !(cdb_stall && |out_valid)`. If issue is disabled, `issued` is 0 for that cycle.
- Selection: start at `rr_ptr` and scan indices `rr_ptr`, `rr_ptr+1`, … modulo `size`. The first `lanes` entries with `ready[i]` are taken. Lane 0 gets the first hit, lane 1 the second, and so on. Lanes with no hit are idle.
- Execute, per lane: `acu_operation[sel]==0` produces the ALU result of the entry's opcode. Otherwise the compare result is produced as 32-bit zero-extended 0/1. The tag is copied from `data[sel]`.
- On an issuing edge:
  - Lane k register loads its result.
  - `out_valid[k]` is set to 1 if lane k had a hit, else 0.
  - `rr_ptr` becomes (last selected index + 1) mod `size`. If nothing was selected, it is unchanged.
- Stall: when `cdb_stall && |out_valid`, all output registers and `rr_ptr` hold.
  - A stall with every `out_valid` at 0 is ignored, so the pipeline fills through the bubble.
- Flush: at the next edge, `out_valid` clears to 0 and `rr_ptr` holds. `flush` overrides `cdb_stall`.
- The block does not track in-flight entries. Correctness relies on the RS dropping `ready[i]` one cycle after `issued[i]`.

## Timing
- Reset values: `out_valid`=0, `out`=all-zero `sal_t`, `rr_ptr`=0. While `rst` is high, `issued`=0.
- Latency: an entry ready in cycle N with issue enabled shows as `out_valid` in cycle N+1.
- Throughput: `lanes` results per cycle, sustained.
- `issued` is purely combinational from `ready`, `rr_ptr`, `flush`, `cdb_stall` and `out_valid`. There is no registered path back to the RS.
- Wrap-around: with `rr_ptr = size-1`, the scan order is `size-1`, 0, 1, ….
- Simultaneous events:
  - `rst` dominates `flush`, which dominates the stall condition.
  - Reset asserted mid-stall discards the held results.
- `rr_ptr` width is `$clog2(size)`. Increment and wrap use modulo-`size` compare, not power-of-two truncation.

## Structure
- `rv32i_types` already holds `rs_t`, `sal_t` and the ALU/compare opcode enums; the ACU select encoding constants are added there too.
- Sub-module `acu_lane`: combinational single-entry execute, one `rs_t` plus operation bit in, one `sal_t` out. It is instantiated `lanes` times.
- The round-robin picker is a generate loop in the top module.

## Test plan
- Single op: `ready`=0x0001, entry 0 ALU add 5+7, tag 3 → next cycle `out_valid`=01, `out[0]` = {tag 3, 12}, `issued`=0x0001 in the issue cycle.
- Dual issue and round-robin:
  - `ready`=0x7FFF with `rr_ptr`=0 → lanes take entries 0 and 1, then `rr_ptr`=2.
  - Next cycle with `ready` still 0x7FFC → entries 2 and 3.
- Wrap: `rr_ptr`=14, `ready` bits 14 and 0 set → lane 0 gets entry 14, lane 1 gets entry 0, `rr_ptr`=1.
- Compare: entry 5 with `acu_operation`=1 computing blt −3 < 2 → `out[0]` value 1. With operands 2, −3 → value 0.
- Backpressure:
  - Valid result held with `cdb_stall`=1 for 3 cycles → `out` stable and `issued`=0 throughout.
  - On release, the next ready entry issues in the same cycle.
- Flush and reset:
  - `flush` during a stall → `out_valid`=0 next cycle.
  - `rst` with valid outputs → all outputs zero next cycle and `rr_ptr`=0.
